// File: rtl/lo_gap_pkg.sv
// Shared types and defaults for the LF downlink gap (pwr_lo) encoder.
// LO_GAP_ENCODER_START_GAP_EN adds the frame-start gap state to the enum.
package lo_gap_pkg;

  localparam int unsigned LEN_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
`ifdef LO_GAP_ENCODER_START_GAP_EN
    ST_START_GAP = 3'd1,
`endif
    ST_GAP       = 3'd2,
    ST_MARK      = 3'd3,
    ST_HOLD      = 3'd4
  } state_e;

  // One downlink bit as held in the buffer / current-bit register.
  typedef struct packed {
    logic data;
    logic last;
  } bit_entry_t;

endpackage

// File: rtl/lo_tick_counter.sv
// Carrier-tick-gated up-counter with load, enable and a combinational done.
// Target of 0 is stored as 1; the count saturates rather than wrapping.
module lo_tick_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_en,
  input  logic             i_tick,
  output logic             o_done_c
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_tgt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_tgt <= CNT_W'(1);
    end else if (i_load) begin
      r_cnt <= '0;
      r_tgt <= (i_len == '0) ? CNT_W'(1) : i_len;
    end else if (i_en && i_tick && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Asserted on the tick that completes the programmed length.
  assign o_done_c = i_tick && (r_cnt == (r_tgt - CNT_W'(1)));

endmodule

// File: rtl/lo_gap_encoder.sv
// Gap/mark downlink encoder: each bit is a field-off gap then a field-on mark.
// Define LO_GAP_ENCODER_START_GAP_EN for a 2*gap_len start gap before each frame.
module lo_gap_encoder
  import lo_gap_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             pck0,
  input  logic             reset_n,
  input  logic             carrier_tick,
  input  logic [LEN_W-1:0] gap_len,
  input  logic [LEN_W-1:0] zero_len,
  input  logic [LEN_W-1:0] one_len,
  input  logic             bit_in,
  input  logic             bit_last,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic             field_off,
  output logic             busy,
  output logic             underrun
);

`ifdef LO_GAP_ENCODER_START_GAP_EN
  localparam int unsigned CNT_W = LEN_W + 1;
`else
  localparam int unsigned CNT_W = LEN_W;
`endif

  state_e           r_state;
  state_e           w_state_nxt;
  bit_entry_t       r_buf;
  bit_entry_t       r_cur;
  logic             r_buf_valid;
  logic             r_bit_ready;
  logic             r_field_off;
  logic             r_busy;
  logic             r_underrun;
  logic [LEN_W-1:0] r_zero_len;
  logic [LEN_W-1:0] r_one_len;

  logic             w_accept;
  logic             w_enter_gap;
  logic             w_frame_start;
  logic             w_set_underrun;
  logic             w_cnt_load;
  logic             w_cnt_en;
  logic             w_cnt_done;
  logic [CNT_W-1:0] w_cnt_len;
  logic             w_off_nxt;

  assign w_accept = bit_valid & r_bit_ready;

`ifdef LO_GAP_ENCODER_START_GAP_EN
  assign w_cnt_en  = (r_state == ST_GAP) || (r_state == ST_MARK) || (r_state == ST_START_GAP);
  assign w_off_nxt = (w_state_nxt == ST_GAP) || (w_state_nxt == ST_START_GAP);
`else
  assign w_cnt_en  = (r_state == ST_GAP) || (r_state == ST_MARK);
  assign w_off_nxt = (w_state_nxt == ST_GAP);
`endif

  lo_tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick_counter (
    .i_clk    (pck0),
    .i_rst_n  (reset_n),
    .i_load   (w_cnt_load),
    .i_len    (w_cnt_len),
    .i_en     (w_cnt_en),
    .i_tick   (carrier_tick),
    .o_done_c (w_cnt_done)
  );

  always_ff @(posedge pck0) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state; every entry into GAP funnels through w_enter_gap.
  always_comb begin
    w_state_nxt    = r_state;
    w_enter_gap    = 1'b0;
    w_frame_start  = 1'b0;
    w_set_underrun = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_len      = CNT_W'(gap_len);
    case (r_state)
      ST_IDLE: begin
        if (r_buf_valid && carrier_tick) begin
          w_frame_start = 1'b1;
`ifdef LO_GAP_ENCODER_START_GAP_EN
          w_state_nxt = ST_START_GAP;
          w_cnt_load  = 1'b1;
          w_cnt_len   = {gap_len, 1'b0};
`else
          w_enter_gap = 1'b1;
`endif
        end
      end
`ifdef LO_GAP_ENCODER_START_GAP_EN
      ST_START_GAP: begin
        if (w_cnt_done) w_enter_gap = 1'b1;
      end
`endif
      ST_GAP: begin
        if (w_cnt_done) begin
          w_state_nxt = ST_MARK;
          w_cnt_load  = 1'b1;
          w_cnt_len   = CNT_W'(r_cur.data ? r_one_len : r_zero_len);
        end
      end
      ST_MARK: begin
        if (w_cnt_done) begin
          if (r_cur.last) begin
            w_state_nxt = ST_IDLE;
          end else if (r_buf_valid) begin
            w_enter_gap = 1'b1;
          end else begin
            w_state_nxt    = ST_HOLD;
            w_set_underrun = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (r_buf_valid && carrier_tick) w_enter_gap = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_enter_gap) begin
      w_state_nxt = ST_GAP;
      w_cnt_load  = 1'b1;
      w_cnt_len   = CNT_W'(gap_len);
    end
  end

  // Holding buffer, current bit and mark lengths latched at gap entry.
  always_ff @(posedge pck0) begin
    if (!reset_n) begin
      r_buf_valid <= 1'b0;
      r_buf       <= '0;
      r_cur       <= '0;
      r_zero_len  <= '0;
      r_one_len   <= '0;
      r_bit_ready <= 1'b0;
    end else begin
      if (w_accept) begin
        r_buf_valid <= 1'b1;
        r_buf       <= '{data: bit_in, last: bit_last};
      end else if (w_enter_gap) begin
        r_buf_valid <= 1'b0;
      end
      if (w_enter_gap) begin
        r_cur      <= r_buf;
        r_zero_len <= zero_len;
        r_one_len  <= one_len;
      end
      r_bit_ready <= ~(w_accept | (r_buf_valid & ~w_enter_gap));
    end
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge pck0) begin
    if (!reset_n) begin
      r_field_off <= 1'b0;
      r_busy      <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_field_off <= w_off_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      if (w_frame_start)       r_underrun <= 1'b0;
      else if (w_set_underrun) r_underrun <= 1'b1;
    end
  end

  assign bit_ready = r_bit_ready;
  assign field_off = r_field_off;
  assign busy      = r_busy;
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_lo_gap_encoder.sv
// Self-checking bench for lo_gap_encoder: directed scenarios plus random frames,
// checked as field_off run lengths (in pck0 cycles) against tick-count rules.
module tb_lo_gap_encoder;

  localparam int unsigned LEN_W = 8;

  logic             pck0 = 1'b0;
  logic             reset_n;
  logic             carrier_tick;
  logic [LEN_W-1:0] gap_len;
  logic [LEN_W-1:0] zero_len;
  logic [LEN_W-1:0] one_len;
  logic             bit_in;
  logic             bit_last;
  logic             bit_valid;
  logic             bit_ready;
  logic             field_off;
  logic             busy;
  logic             underrun;

  int n_checks = 0;
  int n_errors = 0;

  int period = 8;
  int tick_cnt = 0;
  int cur_g, cur_z, cur_o;

  logic       frame_bits[$];
  int         frame_dly[$];
  logic [1:0] tx_q[$];
  int         dly_q[$];
  int         exp_runs[$];
  int         obs_runs[$];
  logic       obs_first;
  logic       obs_timeout;
  logic       obs_underrun;

  lo_gap_encoder #(.LEN_W(LEN_W)) dut (
    .pck0         (pck0),
    .reset_n      (reset_n),
    .carrier_tick (carrier_tick),
    .gap_len      (gap_len),
    .zero_len     (zero_len),
    .one_len      (one_len),
    .bit_in       (bit_in),
    .bit_last     (bit_last),
    .bit_valid    (bit_valid),
    .bit_ready    (bit_ready),
    .field_off    (field_off),
    .busy         (busy),
    .underrun     (underrun)
  );

  always #5 pck0 = ~pck0;

  // Carrier timebase: one-cycle pulse every `period` pck0 cycles.
  initial begin
    carrier_tick = 1'b0;
    forever begin
      @(posedge pck0);
      #1;
      tick_cnt = tick_cnt + 1;
      if (tick_cnt >= period) tick_cnt = 0;
      carrier_tick = (tick_cnt == 0);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic apply_lengths();
    gap_len  = LEN_W'(cur_g);
    zero_len = LEN_W'(cur_z);
    one_len  = LEN_W'(cur_o);
  endtask

  // Expected field_off runs: per bit a gap (high) then a mark (low), in cycles.
  task automatic build_expected();
    exp_runs.delete();
    foreach (frame_bits[i]) begin
      int hi;
      hi = eff(cur_g) * period;
`ifdef LO_GAP_ENCODER_START_GAP_EN
      if (i == 0) hi = hi + eff(2 * cur_g) * period;
`endif
      exp_runs.push_back(hi);
      exp_runs.push_back(eff(frame_bits[i] ? cur_o : cur_z) * period);
    end
  endtask

  task automatic load_tx();
    tx_q.delete();
    dly_q.delete();
    foreach (frame_bits[i]) begin
      tx_q.push_back({frame_bits[i], 1'(i == frame_bits.size() - 1)});
      dly_q.push_back(frame_dly[i]);
    end
  endtask

  task automatic drive_bits();
    while (tx_q.size() > 0) begin
      logic [1:0] e;
      int         dly;
      logic       acc;
      int         guard;
      e   = tx_q.pop_front();
      dly = dly_q.pop_front();
      repeat (dly) @(posedge pck0);
      #1;
      bit_in    = e[1];
      bit_last  = e[0];
      bit_valid = 1'b1;
      acc   = 1'b0;
      guard = 0;
      while (!acc && guard < 4000) begin
        @(negedge pck0);
        acc = bit_ready;
        @(posedge pck0);
        guard++;
      end
      #1 bit_valid = 1'b0;
      check_eq("drv_accept", int'(acc), 1);
    end
  endtask

  // Records field_off run lengths from busy rising to busy falling.
  task automatic capture_frame();
    int   guard;
    int   len;
    logic cur;
    obs_runs.delete();
    obs_first   = 1'b0;
    obs_timeout = 1'b0;
    guard = 0;
    do begin
      @(negedge pck0);
      guard++;
    end while (!busy && guard < 4000);
    if (!busy) begin
      obs_timeout = 1'b1;
      return;
    end
    obs_first = field_off;
    cur = field_off;
    len = 1;
    guard = 0;
    forever begin
      @(negedge pck0);
      guard++;
      if (!busy) begin
        obs_runs.push_back(len);
        break;
      end
      if (guard > 30000) begin
        obs_timeout = 1'b1;
        break;
      end
      if (field_off == cur) len++;
      else begin
        obs_runs.push_back(len);
        cur = field_off;
        len = 1;
      end
    end
    obs_underrun = underrun;
  endtask

  task automatic run_frame();
    load_tx();
    fork
      drive_bits();
      capture_frame();
    join
    repeat (3) @(posedge pck0);
    #1;
  endtask

  task automatic check_runs(input string tag);
    check_eq({tag, "_timeout"}, int'(obs_timeout), 0);
    check_eq({tag, "_first_off"}, int'(obs_first), 1);
    check_eq({tag, "_nruns"}, obs_runs.size(), exp_runs.size());
    for (int i = 0; i < exp_runs.size() && i < obs_runs.size(); i++)
      check_eq($sformatf("%s_run%0d", tag, i), obs_runs[i], exp_runs[i]);
  endtask

  initial begin
    reset_n   = 1'b0;
    bit_in    = 1'b0;
    bit_last  = 1'b0;
    bit_valid = 1'b0;
    cur_g = 3; cur_z = 5; cur_o = 8;
    apply_lengths();

    // Reset state
    repeat (3) @(posedge pck0);
    @(negedge pck0);
    check_eq("rst_field_off", int'(field_off), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_underrun", int'(underrun), 0);
    check_eq("rst_bit_ready", int'(bit_ready), 0);
    @(posedge pck0);
    #1 reset_n = 1'b1;
    @(posedge pck0);
    @(negedge pck0);
    check_eq("post_rst_bit_ready", int'(bit_ready), 1);
    @(posedge pck0);
    #1;

    // Single bit 1, last
    frame_bits = '{1'b1};
    frame_dly  = '{0};
    build_expected();
    run_frame();
    check_runs("single1");
    check_eq("single1_underrun", int'(obs_underrun), 0);

    // Back-to-back 0,1,0
    frame_bits = '{1'b0, 1'b1, 1'b0};
    frame_dly  = '{0, 0, 0};
    build_expected();
    run_frame();
    check_runs("b2b");
    check_eq("b2b_underrun", int'(obs_underrun), 0);

    // Second bit withheld 20 ticks -> HOLD and sticky underrun
    frame_bits = '{1'b1, 1'b0};
    frame_dly  = '{0, 20 * period};
    build_expected();
    run_frame();
    check_eq("hold_timeout", int'(obs_timeout), 0);
    check_eq("hold_nruns", obs_runs.size(), 4);
    if (obs_runs.size() >= 4) begin
      check_eq("hold_gap0", obs_runs[0], exp_runs[0]);
      check_eq("hold_low_exceeds_mark", int'(obs_runs[1] > exp_runs[1]), 1);
      check_eq("hold_resume_gap", obs_runs[2], exp_runs[2]);
      check_eq("hold_resume_mark", obs_runs[3], exp_runs[3]);
    end
    check_eq("hold_underrun", int'(obs_underrun), 1);
    repeat (10) @(posedge pck0);
    @(negedge pck0);
    check_eq("hold_underrun_sticky", int'(underrun), 1);
    @(posedge pck0);
    #1;

    // Zero lengths behave as one tick; underrun clears at frame start
    cur_g = 0; cur_z = 0;
    apply_lengths();
    frame_bits = '{1'b0};
    frame_dly  = '{0};
    build_expected();
    run_frame();
    check_runs("zero_len");
    check_eq("zero_len_underrun_cleared", int'(obs_underrun), 0);

    // Length inputs changed mid-bit are ignored
    cur_g = 3; cur_z = 5; cur_o = 8;
    apply_lengths();
    frame_bits = '{1'b0};
    frame_dly  = '{0};
    build_expected();
    fork
      run_frame();
      begin
        int guard = 0;
        while (!field_off && guard < 4000) begin
          @(negedge pck0);
          guard++;
        end
        @(posedge pck0);
        #1;
        gap_len  = 8'd7;
        zero_len = 8'd2;
        one_len  = 8'd1;
      end
    join
    check_runs("midchg");
    apply_lengths();

    // Reset asserted mid-gap
    frame_bits = '{1'b1, 1'b0};
    frame_dly  = '{0, 0};
    load_tx();
    fork
      drive_bits();
      begin
        int guard = 0;
        while (!field_off && guard < 4000) begin
          @(negedge pck0);
          guard++;
        end
        check_eq("rstgap_reached_gap", int'(field_off), 1);
        repeat (6) @(posedge pck0);
        #1 reset_n = 1'b0;
        @(posedge pck0);
        @(negedge pck0);
        check_eq("rstgap_field_off", int'(field_off), 0);
        check_eq("rstgap_busy", int'(busy), 0);
        check_eq("rstgap_bit_ready", int'(bit_ready), 0);
        @(posedge pck0);
        #1 reset_n = 1'b1;
        @(posedge pck0);
        @(negedge pck0);
        check_eq("rstgap_ready_after", int'(bit_ready), 1);
        check_eq("rstgap_busy_after", int'(busy), 0);
        @(posedge pck0);
        #1;
      end
    join

    // Partial frame discarded: a fresh frame runs cleanly
    frame_bits = '{1'b1};
    frame_dly  = '{0};
    build_expected();
    run_frame();
    check_runs("after_rst");

    // Random frames
    for (int f = 0; f < 12; f++) begin
      int nb;
      period = $urandom_range(4, 9);
      cur_g  = $urandom_range(0, 4);
      cur_z  = $urandom_range(0, 5);
      cur_o  = $urandom_range(0, 6);
      apply_lengths();
      nb = $urandom_range(1, 4);
      frame_bits.delete();
      frame_dly.delete();
      for (int b = 0; b < nb; b++) begin
        frame_bits.push_back(1'($urandom_range(0, 1)));
        frame_dly.push_back(0);
      end
      build_expected();
      run_frame();
      check_runs($sformatf("rnd%0d", f));
      check_eq($sformatf("rnd%0d_underrun", f), int'(obs_underrun), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
